alu_sequencer: RTL and testbench

- Multi-cycle control unit that owns the 8-entry x 16-bit register file and sequences the shared combinational 16-bit ALU (sel 0..7: add, sub, and, or, xor, shl, shr, compare).
- Accepts one instruction per run/done handshake and steps it through operand fetch, execute and writeback.
- Sits between the instruction source (fetch logic or testbench) and the ALU.
- Exposes a load port for register initialisation and a debug read port.

---
 rtl/alu_sequencer.sv | 105 ++++++++++
 tb/tb_alu_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control unit that owns an 8x16 register file and
// steps one instruction at a time through an external combinational ALU.
module alu_sequencer #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [15:0]      instr,
    input  logic             ld_en,
    input  logic [2:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] result,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WB} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [15:0]      instr_q, instr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, result_q, result_d;
    logic [2:0]       sel_q, sel_d;
    logic             done_q, done_d, illegal_q, illegal_d;
    logic [2:0]       rx, ry;
    logic             idle, wb, legal;

    assign rx    = instr_q[15:13];
    assign ry    = instr_q[12:10];
    assign idle  = state_q == IDLE;
    assign wb    = state_q == WB;
    assign legal = ~instr_q[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            sel_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            instr_q   <= instr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            sel_q     <= sel_d;
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Reserved formats skip the operand/execute steps and go straight to WB.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = run ? (instr[1] ? WB : LOAD_A) : IDLE;
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = EXEC;
            EXEC:    state_d = WB;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        regs_d    = regs_q;
        instr_d   = (idle && run) ? instr : instr_q;
        a_d       = (state_q == LOAD_A) ? regs_q[rx] : a_q;
        b_d       = (state_q == LOAD_B) ? (instr_q[0] ? WIDTH'(instr_q[12:5]) : regs_q[ry]) : b_q;
        sel_d     = (state_q == LOAD_B) ? instr_q[4:2] : sel_q;
        c_d       = (state_q == EXEC) ? alu_out : c_q;
        result_d  = (wb && legal) ? c_q : result_q;
        done_d    = wb;
        illegal_d = wb && !legal;
        if (idle && ld_en) regs_d[ld_addr] = ld_data;
        if (wb && legal) regs_d[rx] = c_q;
    end

    always_comb begin
        busy     = !idle;
        done     = done_q;
        illegal  = illegal_q;
        result   = result_q;
        alu_a    = a_q;
        alu_b    = b_q;
        alu_sel  = sel_q;
        dbg_data = regs_q[dbg_addr];
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized checks of alu_sequencer against an
// instruction-level model of the register file and a behavioural ALU.
module tb_alu_sequencer;
    logic        clk = 1'b0, reset_n = 1'b0, run = 1'b0, ld_en = 1'b0;
    logic [15:0] instr = '0, ld_data = '0, alu_out;
    logic [2:0]  ld_addr = '0, dbg_addr = '0;
    logic [15:0] alu_a, alu_b, result, dbg_data;
    logic [2:0]  alu_sel;
    logic        busy, done, illegal;

    int          n_cmp = 0, n_err = 0;
    logic [15:0] m_reg [8];
    logic [15:0] m_result;

    always #10 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset_n(reset_n), .run(run), .instr(instr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .busy(busy), .done(done), .illegal(illegal), .result(result),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel);
        case (sel)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << (b % 16);
            3'd6:    return a >> (b % 16);
            default: return (a == b) ? 16'd0 : (a > b) ? 16'd1 : 16'd2;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_a, alu_b, alu_sel);

    function automatic logic [15:0] enc_rr(input logic [2:0] sel, input logic [2:0] rx, input logic [2:0] ry);
        return {rx, ry, 5'b0, sel, 2'b00};
    endfunction

    function automatic logic [15:0] enc_ri(input logic [2:0] sel, input logic [2:0] rx, input logic [7:0] imm);
        return {rx, imm, sel, 2'b01};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input int i);
        dbg_addr = 3'(i);
        #1;
        check($sformatf("R%0d", i), dbg_data, m_reg[i]);
    endtask

    task automatic chk_all;
        for (int i = 0; i < 8; i++) chk_reg(i);
        check("result", result, m_result);
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick;
        ld_en = 1'b0;
        m_reg[a] = d;
    endtask

    // Issue one instruction from an IDLE cycle and return in its done cycle.
    // Optional noise pulses run/ld_en in busy cycle k (1..4), which must be ignored.
    task automatic issue(input logic [15:0] ins, input int run_noise = 0, input int ld_noise = 0,
                         input logic co_ld = 1'b0, input logic [2:0] co_addr = '0, input logic [15:0] co_data = '0);
        logic [15:0] a, b, r;
        logic [2:0]  rx;
        logic        legal;
        int          k, busy_n;
        run = 1'b1;
        instr = ins;
        if (co_ld) begin
            ld_en = 1'b1;
            ld_addr = co_addr;
            ld_data = co_data;
            m_reg[co_addr] = co_data;
        end
        legal = !ins[1];
        rx = ins[15:13];
        a = m_reg[rx];
        b = ins[0] ? {8'b0, ins[12:5]} : m_reg[ins[12:10]];
        r = alu_ref(a, b, ins[4:2]);
        tick;
        run = 1'b0;
        ld_en = 1'b0;
        k = 1;
        busy_n = 0;
        while (!done && k < 12) begin
            busy_n += int'(busy);
            run = (k == run_noise);
            instr = 16'($urandom);
            ld_en = (k == ld_noise);
            ld_addr = 3'($urandom_range(0, 7));
            ld_data = 16'($urandom);
            tick;
            k++;
        end
        run = 1'b0;
        ld_en = 1'b0;
        check("done_seen", 16'(done), 16'd1);
        check("latency", 16'(k), legal ? 16'd5 : 16'd2);
        check("busy_cycles", 16'(busy_n), legal ? 16'd4 : 16'd1);
        check("busy_in_done", 16'(busy), 16'd0);
        check("illegal", 16'(illegal), 16'(!legal));
        if (legal) begin
            m_reg[rx] = r;
            m_result = r;
        end
        chk_reg(int'(rx));
        check("result", result, m_result);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_result = '0;
        tick;
        tick;
        reset_n = 1'b1;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_illegal", 16'(illegal), 16'd0);
        check("rst_alu_a", alu_a, 16'd0);
        check("rst_alu_b", alu_b, 16'd0);
        check("rst_alu_sel", 16'(alu_sel), 16'd0);
        chk_all;

        load(3'd1, 16'd5);
        load(3'd2, 16'd3);
        issue(enc_rr(3'd0, 3'd1, 3'd2));
        check("add_result", result, 16'd8);
        check("hold_alu_a", alu_a, 16'd5);
        check("hold_alu_b", alu_b, 16'd3);
        check("hold_alu_sel", 16'(alu_sel), 16'd0);
        tick;
        check("done_one_cycle", 16'(done), 16'd0);

        load(3'd3, 16'd10);
        issue(enc_ri(3'd1, 3'd3, 8'd4));
        check("sub_imm", result, 16'd6);
        issue(enc_ri(3'd5, 3'd3, 8'd17));
        check("shl_mod16", result, 16'd12);

        tick;
        load(3'd1, 16'd7);
        load(3'd2, 16'd7);
        issue(enc_rr(3'd7, 3'd1, 3'd2));
        check("cmp_eq", result, 16'd0);
        tick;
        load(3'd4, 16'd9);
        issue(enc_ri(3'd7, 3'd4, 8'd2));
        check("cmp_gt", result, 16'd1);
        tick;
        load(3'd5, 16'd1);
        issue(enc_ri(3'd7, 3'd5, 8'd200));
        check("cmp_lt", result, 16'd2);

        issue({3'd1, 8'hAB, 3'd0, 2'b10});
        tick;
        check("illegal_one_cycle", 16'(illegal), 16'd0);
        chk_all;

        load(3'd1, 16'd4);
        load(3'd2, 16'd4);
        issue(enc_rr(3'd0, 3'd1, 3'd2), 2, 3);
        check("noise_ignored", result, 16'd8);
        issue(enc_rr(3'd0, 3'd1, 3'd1));
        check("back_to_back", result, 16'd16);
        tick;
        check("single_done", 16'(done), 16'd0);
        check("idle_after", 16'(busy), 16'd0);
        chk_all;

        load(3'd6, 16'h1234);
        instr = enc_rr(3'd0, 3'd6, 3'd6);
        run = 1'b1;
        tick;
        run = 1'b0;
        tick;
        tick;
        check("busy_in_exec", 16'(busy), 16'd1);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_result = '0;
        check("rst_mid_busy", 16'(busy), 16'd0);
        check("rst_mid_done", 16'(done), 16'd0);
        check("rst_mid_alu_a", alu_a, 16'd0);
        chk_all;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("no_done_after_rst", 16'(done), 16'd0);
        end
        load(3'd6, 16'd3);
        issue(enc_ri(3'd0, 3'd6, 8'd5));
        check("run_after_rst", result, 16'd8);

        for (int it = 0; it < 40; it++) begin
            logic [15:0] ins;
            int          fsel;
            if ($urandom_range(0, 1) == 1) load(3'($urandom_range(0, 7)), 16'($urandom));
            fsel = int'($urandom_range(0, 5));
            ins = 16'($urandom);
            ins[1:0] = (fsel >= 4) ? 2'(fsel - 2) : 2'(fsel % 2);
            issue(ins, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                tick;
                check("rand_done_pulse", 16'(done), 16'd0);
            end
        end
        tick;
        chk_all;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
